// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, stall hold, flush squash and an
// optional two-entry skid buffer; control bits read as zero whenever the stage holds nothing.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 9,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // state | meaning
  // EMPTY | nothing held, downstream sees a bubble
  // ONE   | main entry valid
  // FULL  | main and skid entries valid (SKID=1 only)
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic              accept, rel;

  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_data_q;
  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // rdy_q is low throughout reset, so the combinational form also stays quiet until the first edge
  assign in_ready = (SKID != 0) ? rdy_q
                                : (rdy_q & ~stall & (~out_valid | out_ready));

  assign accept = in_valid & in_ready & ~stall & ~flush;
  assign rel    = out_valid & out_ready & ~stall;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        main_ctrl_d = '0;
        skid_data_d = '0;
        skid_ctrl_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept && (SKID != 0)) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    rdy_d = (SKID != 0) ? ((state_d != FULL) && !flush) : 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && out_valid && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    bubble_cnt_d = bubble_cnt_q;
    if (!out_valid && out_ready && (bubble_cnt_q != CNT_MAX))
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      rdy_q        <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      rdy_q        <= rdy_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based scoreboard on the skid instance plus directed checks,
// and a small-counter, no-skid instance for saturation and combinational ready.
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset_n;
  logic        in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [8:0]  in_ctrl, out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        s_in_valid, s_in_ready, s_stall, s_flush, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [8:0]  s_in_ctrl, s_out_ctrl;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .stall(s_stall), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of entries the stage owes downstream, capacity two.
  logic [40:0] q[$];
  logic [15:0] st_exp, bu_exp;
  logic        rdy_exp;

  initial begin
    st_exp  = '0;
    bu_exp  = '0;
    rdy_exp = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      st_exp  = '0;
      bu_exp  = '0;
      rdy_exp = 1'b0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(q[0][31:0]));
        chk("out_ctrl", 64'(out_ctrl), 64'(q[0][40:32]));
      end else begin
        chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      end
      chk("in_ready", 64'(in_ready), 64'(rdy_exp));
      chk("stall_cnt", 64'(stall_cnt), 64'(st_exp));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(bu_exp));

      if (stall && q.size() != 0 && st_exp != 16'hFFFF) st_exp = st_exp + 16'd1;
      if (q.size() == 0 && out_ready && bu_exp != 16'hFFFF) bu_exp = bu_exp + 16'd1;
      if (q.size() != 0 && out_ready && !stall) void'(q.pop_front());
      if (in_valid && in_ready && !stall && !flush) q.push_back({in_ctrl, in_data});
      if (flush) q.delete();
      if (q.size() > 2) begin
        n_checks++;
        n_fail++;
        $display("FAIL capacity: got %0d entries expected at most 2", q.size());
      end
      rdy_exp = (q.size() < 2) && !flush;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [8:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    for (int k = 0; k < 20; k++) begin
      if (in_ready && !stall && !flush) begin
        cyc();
        return;
      end
      cyc();
    end
    n_checks++;
    n_fail++;
    $display("FAIL push_timeout: word 0x%0h not accepted within 20 cycles", d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] b_mark, s_mark;

  initial begin
    reset_n = 1'b1;
    {in_valid, stall, flush, out_ready} = '0;
    in_data = '0; in_ctrl = '0;
    {s_in_valid, s_stall, s_flush, s_out_ready} = '0;
    s_in_data = '0; s_in_ctrl = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    cyc();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Back-to-back stream with one-cycle latency and no bubbles once flowing
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(32'h10 + 32'(i), 9'(i * 37));
      if (i == 0) b_mark = bu_exp;
      chk("stream_latency", 64'(out_data), 64'(32'h10 + 32'(i)));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    chk("stream_no_bubble", 64'(bubble_cnt), 64'(b_mark));
    in_valid = 1'b0;
    repeat (3) cyc();

    // Downstream backpressure fills the skid entry
    push_word(32'h20, 9'h020);
    out_ready = 1'b0;
    push_word(32'h21, 9'h021);
    chk("full_occ", 64'(occupancy), 64'd2);
    chk("full_ready", 64'(in_ready), 64'd0);
    in_data = 32'h22; in_ctrl = 9'h022;
    repeat (2) cyc();
    chk("full_hold_occ", 64'(occupancy), 64'd2);
    chk("full_hold_head", 64'(out_data), 64'h20);
    out_ready = 1'b1;
    push_word(32'h22, 9'h022);
    push_word(32'h23, 9'h023);
    in_valid = 1'b0;
    repeat (4) cyc();

    // Stall freezes a held entry and counts cycles
    out_ready = 1'b0;
    push_word(32'hABCD, 9'h1FF);
    in_valid = 1'b1; in_data = 32'h5555; in_ctrl = 9'h055;
    out_ready = 1'b1;
    stall = 1'b1;
    s_mark = st_exp;
    repeat (4) cyc();
    chk("stall_data", 64'(out_data), 64'hABCD);
    chk("stall_ctrl", 64'(out_ctrl), 64'h1FF);
    chk("stall_cnt4", 64'(stall_cnt), 64'(s_mark + 16'd4));
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) cyc();

    // Flush of a full stage with an offered word, then flush together with stall
    out_ready = 1'b0;
    push_word(32'h30, 9'h030);
    push_word(32'h31, 9'h031);
    in_valid = 1'b1; in_data = 32'h99; in_ctrl = 9'h099;
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_data", 64'(out_data), 64'd0);
    cyc();
    push_word(32'h40, 9'h040);
    push_word(32'h41, 9'h041);
    in_valid = 1'b1; in_data = 32'h9A; in_ctrl = 9'h09A;
    stall = 1'b1; flush = 1'b1;
    cyc();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("flush_stall_occ", 64'(occupancy), 64'd0);
    chk("flush_stall_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset in the middle of a stream
    push_word(32'h50, 9'h050);
    push_word(32'h51, 9'h051);
    in_data = 32'h52;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    chk("arst_cnt", 64'({stall_cnt, bubble_cnt}), 64'd0);
    in_valid = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    push_word(32'h77, 9'h0AA);
    chk("arst_latency_data", 64'(out_data), 64'h77);
    chk("arst_latency_ctrl", 64'(out_ctrl), 64'h0AA);
    in_valid = 1'b0;
    repeat (2) cyc();

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = 9'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end
    {in_valid, stall, flush} = '0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("drained", 64'(occupancy), 64'd0);

    // No-skid instance: combinational ready and 4-bit saturating stall counter
    s_in_valid = 1'b1; s_in_data = 32'h42; s_in_ctrl = 9'h1FF;
    #1 chk("s_ready_empty", 64'(s_in_ready), 64'd1);
    cyc();
    s_in_valid = 1'b0;
    chk("s_valid", 64'(s_out_valid), 64'd1);
    chk("s_ready_blocked", 64'(s_in_ready), 64'd0);
    s_out_ready = 1'b1;
    #1 chk("s_ready_comb", 64'(s_in_ready), 64'd1);
    s_stall = 1'b1;
    #1 chk("s_ready_stall", 64'(s_in_ready), 64'd0);
    repeat (20) cyc();
    chk("s_stall_sat", 64'(s_stall_cnt), 64'd15);
    chk("s_hold_data", 64'(s_out_data), 64'h42);
    chk("s_hold_occ", 64'(s_occupancy), 64'd1);
    s_stall = 1'b0;
    cyc();
    chk("s_released", 64'(s_out_valid), 64'd0);
    chk("s_bubble_ctrl", 64'(s_out_ctrl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
